// File: rtl/keyboard_ps2_wb.sv
// PS/2 keyboard receiver with a scan-code FIFO behind a single-register
// STB/ACK bus slave: reads pop one code plus status, writes flush or clear flags.
`timescale 1ns/1ps

module keyboard_ps2_wb #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2C,
    input  logic        PS2D,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic        ACK,
    output logic [31:0] DAT_O
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_ps2c_sync, r_ps2d_sync;
    logic          r_ps2c_prev;
    state_t        r_state, w_next_state;
    logic [2:0]    r_bit_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_shift, r_push_data;
    logic          r_parity, r_push_pend;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ack, r_stb_block, r_ovf, r_err;
    logic [31:0]   r_dat_o;

    logic w_fall, w_ps2d, w_timeout, w_frame_good, w_frame_ok, w_frame_bad;
    logic w_bus_go, w_rd, w_wr, w_flush, w_clr, w_empty, w_full, w_pop, w_push, w_ovf_set;
    logic [4:0] w_count_ext;
    logic       w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps2c_sync <= 2'b11;
            r_ps2d_sync <= 2'b11;
            r_ps2c_prev <= 1'b1;
        end else begin
            r_ps2c_sync <= {r_ps2c_sync[0], PS2C};
            r_ps2d_sync <= {r_ps2d_sync[0], PS2D};
            r_ps2c_prev <= r_ps2c_sync[1];
        end
    end

    assign w_fall    = r_ps2c_prev & ~r_ps2c_sync[1];
    assign w_ps2d    = r_ps2d_sync[1];
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Odd parity: data bits plus parity bit must carry an odd number of ones.
    assign w_frame_good = w_ps2d && (^{r_shift, r_parity});
    assign w_frame_ok   = w_fall && (r_state == S_STOP) && w_frame_good;
    assign w_frame_bad  = w_fall && (r_state == S_STOP) && !w_frame_good;

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        if (w_timeout) begin
            w_next_state = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_ps2d) w_next_state = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_next_state = S_PARITY;
                S_PARITY: w_next_state = S_STOP;
                S_STOP:   w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_to_cnt    <= '0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_push_pend <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_push_pend <= w_frame_ok;
            if (w_frame_ok) r_push_data <= r_shift;

            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + TW'(1);

            if (w_timeout) begin
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_shift   <= {w_ps2d, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_ps2d;
                    default:  ;
                endcase
            end
        end
    end

    // A bus action fires once, on the cycle ACK rises; STB held through reset is ignored until it drops.
    assign w_bus_go  = STB && !r_ack && !r_stb_block;
    assign w_rd      = w_bus_go && !WE;
    assign w_wr      = w_bus_go && WE;
    assign w_flush   = w_wr && DAT_I[0];
    assign w_clr     = w_wr && DAT_I[1];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = w_rd && !w_empty;
    assign w_push    = r_push_pend && !w_flush && (!w_full || w_pop);
    assign w_ovf_set = r_push_pend && !w_flush && w_full && !w_pop;
    assign w_count_ext = 5'(r_count);
    assign w_unused  = &{1'b0, DAT_I[31:2], w_count_ext[4]};

    // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack       <= 1'b0;
            r_stb_block <= 1'b1;
            r_dat_o     <= 32'h0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (!STB) r_stb_block <= 1'b0;

            if (!STB)         r_ack <= 1'b0;
            else if (w_bus_go) r_ack <= 1'b1;

            if (w_rd)
                r_dat_o <= {!w_empty, r_ovf, r_err, 9'b0, w_count_ext[3:0], 8'b0,
                            w_empty ? 8'h00 : r_mem[r_rd_ptr]};

            if (w_ovf_set)  r_ovf <= 1'b1;
            else if (w_clr) r_ovf <= 1'b0;
            if (w_frame_bad) r_err <= 1'b1;
            else if (w_clr)  r_err <= 1'b0;
        end
    end

    assign ACK   = r_ack;
    assign DAT_O = r_dat_o;

endmodule

// File: tb/tb_keyboard_ps2_wb.sv
// Directed bench for keyboard_ps2_wb: PS/2 frames are bit-banged and results
// are read back over the STB/ACK bus against hand-computed register values.
`timescale 1ns/1ps

module tb_keyboard_ps2_wb;

    localparam int DEPTH = 8;
    localparam int TO    = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        PS2C, PS2D, STB, WE;
    logic [31:0] DAT_I;
    logic        ACK;
    logic [31:0] DAT_O;

    int tests_run    = 0;
    int tests_failed = 0;

    keyboard_ps2_wb #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D),
        .STB(STB), .WE(WE), .DAT_I(DAT_I), .ACK(ACK), .DAT_O(DAT_O)
    );

    always #5 clk = ~clk;

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        PS2D = b;
        clk_wait(5);
        PS2C = 1'b0;
        clk_wait(10);
        PS2C = 1'b1;
        clk_wait(5);
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        clk_wait(5);
    endtask

    task automatic bus_read(output logic [31:0] d, output int lat);
        STB = 1'b1;
        WE  = 1'b0;
        lat = 0;
        while (ACK !== 1'b1 && lat < 10) begin
            clk_wait(1);
            lat++;
        end
        if (ACK !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL read_ack_timeout: ACK=%b after %0d cycles, required 1", ACK, lat);
        end
        d   = DAT_O;
        STB = 1'b0;
        clk_wait(2);
    endtask

    task automatic bus_write(input logic [31:0] d);
        int lat;
        STB   = 1'b1;
        WE    = 1'b1;
        DAT_I = d;
        lat   = 0;
        while (ACK !== 1'b1 && lat < 10) begin
            clk_wait(1);
            lat++;
        end
        if (ACK !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_ack_timeout: ACK=%b after %0d cycles, required 1", ACK, lat);
        end
        STB   = 1'b0;
        WE    = 1'b0;
        DAT_I = 32'h0;
        clk_wait(2);
    endtask

    task automatic expect_read(input string name, input logic [31:0] exp);
        logic [31:0] d;
        int lat;
        bus_read(d, lat);
        tests_run++;
        if (d !== exp) begin
            tests_failed++;
            $display("FAIL %s: DAT_O=%h required %h", name, d, exp);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int lat;
        rst = 1'b1; PS2C = 1'b1; PS2D = 1'b1; STB = 1'b0; WE = 1'b0; DAT_I = 32'h0;
        clk_wait(3);
        tests_run++;
        if (ACK !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ack: ACK=%b required 0", ACK);
        end
        tests_run++;
        if (DAT_O !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_dat: DAT_O=%h required 00000000", DAT_O);
        end
        rst = 1'b0;
        clk_wait(3);
        bus_read(d, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL reset_read_latency: ACK after %0d cycles, required 1", lat);
        end
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_read_empty: DAT_O=%h required 00000000", d);
        end
    endtask

    task automatic test_basic_frame;
        logic [31:0] d;
        int lat;
        ps2_frame(8'h1C, 1'b0);
        bus_read(d, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL basic_latency: ACK after %0d cycles, required 1", lat);
        end
        tests_run++;
        if (d !== 32'h8001001C) begin
            tests_failed++;
            $display("FAIL basic_read: DAT_O=%h required 8001001c", d);
        end
        expect_read("basic_read_empty", 32'h0000_0000);
    endtask

    task automatic test_parity_error;
        ps2_frame(8'h1C, 1'b1);
        expect_read("parity_err_flag", 32'h2000_0000);
        bus_write(32'h2);
        expect_read("parity_err_cleared", 32'h0000_0000);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) ps2_frame(8'(i), 1'b0);
        for (int i = 1; i <= 8; i++)
            expect_read($sformatf("ovf_read_%0d", i), 32'hC000_0000 | ((9 - i) << 16) | i);
        expect_read("ovf_drained", 32'h4000_0000);
        bus_write(32'h3);
        expect_read("ovf_cleared", 32'h0000_0000);
    endtask

    task automatic test_flush;
        ps2_frame(8'hA3, 1'b0);
        ps2_frame(8'h47, 1'b0);
        bus_write(32'h1);
        expect_read("flush_empty", 32'h0000_0000);
        ps2_frame(8'h66, 1'b0);
        expect_read("flush_ptr_restart", 32'h8001_0066);
    endtask

    task automatic test_timeout;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        PS2D = 1'b1;
        clk_wait(TO + 1);
        ps2_frame(8'h5A, 1'b0);
        expect_read("timeout_then_frame", 32'h8001_005A);
        expect_read("timeout_no_extra", 32'h0000_0000);
    endtask

    task automatic test_hold_stb;
        int ack_hi;
        int bad_dat;
        ps2_frame(8'h11, 1'b0);
        ps2_frame(8'h22, 1'b0);
        STB = 1'b1;
        WE  = 1'b0;
        ack_hi  = 0;
        bad_dat = 0;
        for (int k = 1; k <= 20; k++) begin
            clk_wait(1);
            if (ACK === 1'b1) ack_hi++;
            if (DAT_O !== 32'h8002_0011) bad_dat++;
        end
        STB = 1'b0;
        clk_wait(1);
        tests_run++;
        if (ack_hi !== 20) begin
            tests_failed++;
            $display("FAIL hold_ack_cycles: ACK high %0d cycles, required 20", ack_hi);
        end
        tests_run++;
        if (bad_dat !== 0) begin
            tests_failed++;
            $display("FAIL hold_dat_stable: %0d cycles DAT_O!=80020011, required 0 (last %h)", bad_dat, DAT_O);
        end
        tests_run++;
        if (ACK !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ack_drop: ACK=%b required 0", ACK);
        end
        clk_wait(1);
        expect_read("hold_single_pop", 32'h8001_0022);
        expect_read("hold_empty", 32'h0000_0000);
    endtask

    task automatic test_reset_mid;
        logic [7:0] partial;
        int ack_seen;
        partial = 8'hB7;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(partial[i]);
        PS2D = partial[5];
        clk_wait(3);
        rst = 1'b1;
        STB = 1'b1;
        WE  = 1'b0;
        clk_wait(2);
        rst = 1'b0;
        ack_seen = 0;
        for (int k = 0; k < 5; k++) begin
            clk_wait(1);
            if (ACK !== 1'b0) ack_seen++;
        end
        tests_run++;
        if (ack_seen !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_stb_ignored: ACK high %0d cycles, required 0", ack_seen);
        end
        STB  = 1'b0;
        PS2D = 1'b1;
        clk_wait(2);
        ps2_frame(8'h29, 1'b0);
        expect_read("rstmid_frame", 32'h8001_0029);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity_error();
        test_overflow();
        test_flush();
        test_timeout();
        test_hold_stb();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keyboard_ps2_wb.md
KEYBOARD_PS2_WB -- requirements
Module: keyboard_ps2_wb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: scan-code FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a PS2 clock falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1: system clock, 100 MHz; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port PS2C, input, 1: PS/2 clock from keyboard; asynchronous.
REQ-006 SHALL have port PS2D, input, 1: PS/2 data from keyboard; asynchronous.
REQ-007 SHALL have port STB, input, 1: bus strobe; held by master until ACK seen.
REQ-008 SHALL have port WE, input, 1: bus write enable; valid while STB=1.
REQ-009 SHALL have port DAT_I, input, 32: bus write data.
REQ-010 SHALL have port ACK, output, 1: bus acknowledge.
REQ-011 SHALL have port DAT_O, output, 32: bus read data.

Function
REQ-012 SHALL pass PS2C and PS2D each through a 2-flop synchronizer; a falling edge is synchronized PS2C 1 then 0 on consecutive cycles.
REQ-013 SHALL run a receive FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on falling edges, sampling synchronized PS2D.
REQ-014 SHALL, in IDLE, enter DATA on a falling edge with data=0 (start bit); start bit 1 is ignored, FSM stays IDLE.
REQ-015 SHALL, in DATA, shift 8 bits LSB first using a 3-bit bit counter, entering PARITY after the 8th bit.
REQ-016 SHALL, in PARITY, sample the parity bit; in STOP, accept the frame only if data bits plus parity have odd weight and stop bit is 1.
REQ-017 SHALL push an accepted byte into the FIFO on the cycle after the stop-bit edge; a rejected frame sets sticky err flag and pushes nothing.
REQ-018 SHALL return to IDLE and discard the partial frame when in DATA/PARITY/STOP and TIMEOUT_CYC cycles pass without a falling edge; no flag set.
REQ-019 SHALL, on push while FIFO full, drop the byte and set sticky ovf flag; FIFO contents unchanged.
REQ-020 SHALL keep count 0..FIFO_DEPTH with wrapping read/write pointers; simultaneous push and pop both take effect, count unchanged.
REQ-021 SHALL assert ACK on the cycle after STB is first sampled 1, hold ACK while STB=1, deassert ACK the cycle after STB=0; the bus action executes exactly once per STB assertion, on the ACK-rising cycle.
REQ-022 SHALL, on read (WE=0), latch DAT_O = {valid, ovf, err, 9'b0, count[3:0], 8'b0, code[7:0]}; valid=1 and FIFO head popped if count>0; valid=0, code=0 and no pop if empty; count is value before pop.
REQ-023 SHALL hold DAT_O stable while ACK=1.
REQ-024 SHALL, on write (WE=1): DAT_I[0]=1 flush FIFO (count=0, pointers 0); DAT_I[1]=1 clear ovf and err; both bits may be set together; a push on the same cycle as a flush is discarded.
REQ-025 SHALL continue receiving during bus transactions; a frame is never lost because of bus activity.

Reset
REQ-026 SHALL, while rst=1, asynchronously force ACK=0, DAT_O=0, FSM=IDLE, bit counter=0, timeout counter=0, count=0, pointers=0, ovf=0, err=0, synchronizer flops=1.
REQ-027 SHALL, on rst mid-frame or mid-transaction, discard the partial frame and ignore the pending STB until it drops and reasserts.

Verification
REQ-028 Scenario: send frame 0x1C (parity 0, stop 1), then read -> ACK one cycle after STB, DAT_O=0x8001001C; next read -> DAT_O=0x00000000.
REQ-029 Scenario: send 0x1C with parity 1 -> no push, read returns 0x20000000; write DAT_I=0x2 then read -> 0x00000000.
REQ-030 Scenario: send 9 valid frames 0x01..0x09 with FIFO_DEPTH=8 -> first read 0xC0080001, eight reads return 0x01..0x08, 0x09 absent.
REQ-031 Scenario: start bit plus 4 data bits, idle TIMEOUT_CYC+1 cycles, then full frame 0x5A -> single read returns 0x8001005A.
REQ-032 Scenario: hold STB=1 WE=0 for 20 cycles with 2 bytes queued -> ACK high cycles 2..21, one pop, count then 1.
REQ-033 Scenario: pulse rst during bit 5 of a frame, then send 0x29 -> read returns 0x80010029, ovf=0, err=0.
